// File: rtl/ofmap_byte_packer.sv
// rtl/ofmap_byte_packer.sv - packs int8 conv results four per 32-bit AXI-Stream word
module ofmap_byte_packer #(
  parameter int C_S_R_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_P_AXIS_TDATA_WIDTH = 32,
  parameter int C_CNT_WIDTH            = 16
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic [C_S_R_AXIS_TDATA_WIDTH-1:0] s_r_axis_tdata,
  input  logic                              s_r_axis_tvalid,
  input  logic                              s_r_axis_tlast,
  output logic                              s_r_axis_tready,
  output logic [C_M_P_AXIS_TDATA_WIDTH-1:0] m_p_axis_tdata,
  output logic [3:0]                        m_p_axis_tstrb,
  output logic                              m_p_axis_tlast,
  output logic                              m_p_axis_tvalid,
  input  logic                              m_p_axis_tready,
  output logic [C_CNT_WIDTH-1:0]            frame_bytes,
  output logic                              frame_done
);

  logic [1:0]             lane;
  logic [23:0]            pack;
  logic [C_CNT_WIDTH-1:0] run_cnt;

  logic [7:0]             in_byte;
  logic                   accept;
  logic                   emit;
  logic [31:0]            merged;
  logic [3:0]             strb;
  logic [C_CNT_WIDTH-1:0] cnt_inc;
  logic                   unused_hi;

  assign in_byte   = s_r_axis_tdata[7:0];
  assign unused_hi = ^s_r_axis_tdata[C_S_R_AXIS_TDATA_WIDTH-1:8];

  // Stall whenever the output register is occupied and not draining, regardless of lane.
  assign s_r_axis_tready = s_axi_aresetn & (~m_p_axis_tvalid | m_p_axis_tready);
  assign accept          = s_r_axis_tvalid & s_r_axis_tready;
  assign emit            = accept & ((lane == 2'd3) | s_r_axis_tlast);
  assign frame_done      = m_p_axis_tvalid & m_p_axis_tready & m_p_axis_tlast;

  // Lanes above the current one are always zero because pack is cleared on every emit.
  assign merged  = {8'h00, pack} | ({24'h000000, in_byte} << {lane, 3'b000});
  assign cnt_inc = (run_cnt == '1) ? run_cnt : run_cnt + C_CNT_WIDTH'(1);

  always_comb begin
    strb = 4'b0001;
    case (lane)
      2'd0: strb = 4'b0001;
      2'd1: strb = 4'b0011;
      2'd2: strb = 4'b0111;
      2'd3: strb = 4'b1111;
      default: strb = 4'b0001;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      lane    <= 2'd0;
      pack    <= 24'h0;
      run_cnt <= '0;
    end else if (accept) begin
      if (emit) begin
        lane <= 2'd0;
        pack <= 24'h0;
      end else begin
        lane <= lane + 2'd1;
        pack <= merged[23:0];
      end
      run_cnt <= s_r_axis_tlast ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      frame_bytes <= '0;
    end else if (accept && s_r_axis_tlast) begin
      frame_bytes <= cnt_inc;
    end
  end

  // Output register: a new word may replace one being handed off in the same cycle.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      m_p_axis_tvalid <= 1'b0;
      m_p_axis_tdata  <= '0;
      m_p_axis_tstrb  <= 4'b0000;
      m_p_axis_tlast  <= 1'b0;
    end else if (emit) begin
      m_p_axis_tvalid <= 1'b1;
      m_p_axis_tdata  <= C_M_P_AXIS_TDATA_WIDTH'(merged);
      m_p_axis_tstrb  <= strb;
      m_p_axis_tlast  <= s_r_axis_tlast;
    end else if (m_p_axis_tready) begin
      m_p_axis_tvalid <= 1'b0;
    end
  end

endmodule
